ft_recovery_ctrl: RTL and testbench
===================================

Name: ft_recovery_ctrl

Overview:
Fault-recovery controller that sits directly downstream of the comparing shared GPR file (comp_sgpr). It consumes the comparator's mismatch flag and freezes both lockstep cores. It then drives a rollback request/acknowledge handshake, resumes execution, and counts retries. If retries run out it escalates to a latched fatal state. It is the only consumer of the comparator mismatch output.

Parameters:
DRAIN_CYCLES, 4, cycles halt_o is held before the rollback request is raised; legal range >=1.
MAX_RETRY, 3, rollbacks allowed before a further mismatch escalates to FATAL.
CLEAN_WINDOW, 16, consecutive mismatch-free IDLE cycles that clear retry_cnt_o.
CNT_W, 8, width of fault_cnt_o.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cmp_valid_i  in  1  comparator result valid this cycle (a GPR write is occurring).
mismatch_i  in  1  comparator mismatch flag; sampled only when cmp_valid_i=1.
rollback_ack_i  in  1  cores report that the checkpoint restore is complete.
clear_i  in  1  software clear of the FATAL state.
halt_o  out  1  stalls both cores.
rollback_req_o  out  1  checkpoint restore request.
resume_o  out  1  single-cycle restart pulse.
fatal_o  out  1  unrecoverable fault, latched.
retry_cnt_o  out  $clog2(MAX_RETRY+1)  rollbacks since the last clean window.
fault_cnt_o  out  CNT_W  saturating total of accepted mismatches.

Behaviour:
- Reset: state=IDLE, all outputs 0, internal counters 0. Reset asserted mid-operation drops halt_o and rollback_req_o immediately (asynchronous).
- Mismatch acceptance: a mismatch is accepted only in IDLE, and only when cmp_valid_i & mismatch_i at a clock edge. Mismatches in any other state are ignored and not counted.
- On accept:
  - fault_cnt_o increments and saturates at 2^CNT_W-1.
  - If retry_cnt_o==MAX_RETRY, next state is FATAL.
  - Otherwise next state is HALT, with the drain counter loaded to DRAIN_CYCLES-1.
- IDLE:
  - halt_o=0.
  - While retry_cnt_o>0, a clean counter increments on every cycle without an accepted mismatch.
  - An accepted mismatch resets the clean counter.
  - When the clean counter reaches CLEAN_WINDOW, retry_cnt_o clears to 0 and the clean counter clears to 0.
- HALT:
  - halt_o=1.
  - The drain counter decrements each cycle.
  - In the cycle the drain counter ==0, next state is ROLLBACK.
  - HALT lasts exactly DRAIN_CYCLES cycles.
- ROLLBACK:
  - halt_o=1 and rollback_req_o=1; both hold until rollback_ack_i is sampled high.
  - On ack, next state is RESUME and retry_cnt_o increments.
  - An ack in the same cycle as ROLLBACK entry is not possible: the ack is only sampled while already in ROLLBACK.
  - rollback_ack_i in any other state is ignored.
- RESUME:
  - resume_o=1 for exactly one cycle; halt_o=0, rollback_req_o=0.
  - Next state is IDLE.
  - The clean counter clears to 0.
- FATAL:
  - halt_o=1 and fatal_o=1, held indefinitely.
  - clear_i goes to IDLE and clears retry_cnt_o and the clean counter.
  - fault_cnt_o is retained.
  - clear_i in any other state is ignored.
- All outputs are registered. Latency from an accepted mismatch edge to halt_o=1 is one cycle (visible after that edge).
- The counter widths never wrap: retry_cnt_o cannot exceed MAX_RETRY by construction.

Decomposition:
- Package ft_pkg holds the state enum typedef rec_state_t {IDLE, HALT, ROLLBACK, RESUME, FATAL} and the default constants for DRAIN_CYCLES, MAX_RETRY, CLEAN_WINDOW and CNT_W.
- One sub-module, ft_sat_counter (parameterised width, inc/clr inputs, saturates at the all-ones value), is used for fault_cnt_o.
- The FSM, drain counter and clean counter stay in ft_recovery_ctrl.

Test Plan:
1. Reset, then idle 20 cycles with cmp_valid_i=1 and mismatch_i=0 -> all outputs stay 0.
2. Defaults; single accepted mismatch at cycle 0 -> halt_o=1 from cycle 1, rollback_req_o=1 from cycle 5. Ack at cycle 8 -> resume_o=1 at cycle 9 only, halt_o=0 at cycle 9, retry_cnt_o=1, fault_cnt_o=1.
3. mismatch_i=1 with cmp_valid_i=0; then mismatches pulsed during HALT and ROLLBACK -> none accepted, fault_cnt_o increments by exactly 1 for the initial accept only.
4. Four mismatch/rollback cycles, each separated by fewer than 16 clean cycles -> fourth mismatch goes to FATAL: fatal_o=1, halt_o=1, retry_cnt_o=3, fault_cnt_o=4. clear_i -> IDLE with retry_cnt_o=0 and fault_cnt_o still 4.
5. One rollback, then 16 clean IDLE cycles -> retry_cnt_o returns 0. Three more rollbacks complete without FATAL.
6. Assert rst while rollback_req_o=1 -> rollback_req_o and halt_o drop before the next clk edge. After release, state is IDLE and a late rollback_ack_i is ignored.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and default sizing for the lockstep fault-recovery controller.
// Imported by ft_recovery_ctrl and its saturating counter.
package ft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ROLLBACK,
    RESUME,
    FATAL
  } rec_state_t;

  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CLEAN_WINDOW = 16;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/ft_sat_counter.sv
// Up-counter that sticks at its all-ones value.
// Used for the lifetime fault tally.
module ft_sat_counter
  import ft_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep fault recovery: freeze, rollback handshake, resume,
// retry accounting and escalation to a latched fatal state.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CLEAN_WINDOW = DEF_CLEAN_WINDOW,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_valid_i,
  input  logic             mismatch_i,
  input  logic             rollback_ack_i,
  input  logic             clear_i,
  output logic             halt_o,
  output logic             rollback_req_o,
  output logic             resume_o,
  output logic             fatal_o,
  output logic [RW-1:0]    retry_cnt_o,
  output logic [CNT_W-1:0] fault_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int CW = $clog2(CLEAN_WINDOW + 1);

  rec_state_t    state, nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic [CW-1:0] clean, clean_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          accept;

  assign accept = (state == IDLE) && cmp_valid_i && mismatch_i;
  assign retry_cnt_o = retry;

  always_comb begin
    nxt       = state;
    drain_nxt = drain;
    clean_nxt = clean;
    retry_nxt = retry;
    unique case (state)
      IDLE: begin
        if (accept) begin
          clean_nxt = '0;
          if (retry == RW'(MAX_RETRY)) begin
            nxt = FATAL;
          end else begin
            nxt       = HALT;
            drain_nxt = DW'(DRAIN_CYCLES - 1);
          end
        end else if (retry != '0) begin
          if (clean == CW'(CLEAN_WINDOW - 1)) begin
            clean_nxt = '0;
            retry_nxt = '0;
          end else begin
            clean_nxt = clean + CW'(1);
          end
        end
      end
      HALT: begin
        if (drain == '0) begin
          nxt = ROLLBACK;
        end else begin
          drain_nxt = drain - DW'(1);
        end
      end
      ROLLBACK: begin
        if (rollback_ack_i) begin
          nxt       = RESUME;
          retry_nxt = retry + RW'(1);
        end
      end
      RESUME: begin
        nxt       = IDLE;
        clean_nxt = '0;
      end
      FATAL: begin
        if (clear_i) begin
          nxt       = IDLE;
          retry_nxt = '0;
          clean_nxt = '0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      drain          <= '0;
      clean          <= '0;
      retry          <= '0;
      halt_o         <= 1'b0;
      rollback_req_o <= 1'b0;
      resume_o       <= 1'b0;
      fatal_o        <= 1'b0;
    end else begin
      state          <= nxt;
      drain          <= drain_nxt;
      clean          <= clean_nxt;
      retry          <= retry_nxt;
      halt_o         <= (nxt == HALT) || (nxt == ROLLBACK) || (nxt == FATAL);
      rollback_req_o <= (nxt == ROLLBACK);
      resume_o       <= (nxt == RESUME);
      fatal_o        <= (nxt == FATAL);
    end
  end

  ft_sat_counter #(
    .W(CNT_W)
  ) u_fault_cnt (
    .clk(clk),
    .rst(rst),
    .inc(accept),
    .clr(1'b0),
    .cnt(fault_cnt_o)
  );

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: directed table, corner sequences,
// then random traffic against a behavioural model.
module tb_ft_recovery_ctrl;

  localparam int DRAIN  = 4;
  localparam int MAXR   = 3;
  localparam int CLEANW = 16;
  localparam int CNTW   = 8;
  localparam int RW     = $clog2(MAXR + 1);
  localparam int SAT    = (1 << CNTW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_HALT  = 1;
  localparam int PH_RB    = 2;
  localparam int PH_RES   = 3;
  localparam int PH_FATAL = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmp_valid = 1'b0;
  logic            mismatch = 1'b0;
  logic            ack = 1'b0;
  logic            clr = 1'b0;
  logic            halt, req, resume, fatal;
  logic [RW-1:0]   retry;
  logic [CNTW-1:0] fault;

  ft_recovery_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .MAX_RETRY(MAXR),
    .CLEAN_WINDOW(CLEANW),
    .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmp_valid_i(cmp_valid),
    .mismatch_i(mismatch),
    .rollback_ack_i(ack),
    .clear_i(clr),
    .halt_o(halt),
    .rollback_req_o(req),
    .resume_o(resume),
    .fatal_o(fatal),
    .retry_cnt_o(retry),
    .fault_cnt_o(fault)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // Behavioural model: phase plus remaining halt cycles and counters.
  int m_phase, m_left, m_retry, m_fault, m_clean;

  function automatic void model_reset();
    m_phase = PH_IDLE;
    m_left  = 0;
    m_retry = 0;
    m_fault = 0;
    m_clean = 0;
  endfunction

  function automatic void model_step(logic cv, logic mm, logic ak, logic cl);
    case (m_phase)
      PH_IDLE: begin
        if (cv && mm) begin
          m_fault = (m_fault < SAT) ? m_fault + 1 : SAT;
          m_clean = 0;
          if (m_retry == MAXR) m_phase = PH_FATAL;
          else begin
            m_phase = PH_HALT;
            m_left  = DRAIN;
          end
        end else if (m_retry > 0) begin
          m_clean++;
          if (m_clean == CLEANW) begin
            m_retry = 0;
            m_clean = 0;
          end
        end
      end
      PH_HALT: begin
        m_left--;
        if (m_left == 0) m_phase = PH_RB;
      end
      PH_RB: if (ak) begin
        m_phase = PH_RES;
        m_retry++;
      end
      PH_RES: begin
        m_phase = PH_IDLE;
        m_clean = 0;
      end
      default: if (cl) begin
        m_phase = PH_IDLE;
        m_retry = 0;
        m_clean = 0;
      end
    endcase
  endfunction

  task automatic apply(input logic cv, input logic mm,
                       input logic ak, input logic cl);
    cmp_valid = cv;
    mismatch  = mm;
    ack       = ak;
    clr       = cl;
    @(posedge clk);
    model_step(cv, mm, ak, cl);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] eo,
                           input int er, input int ef);
    vecs++;
    if ({halt, req, resume, fatal} !== eo ||
        int'(retry) != er || int'(fault) != ef) begin
      miss++;
      $display("FAIL %s: got h/q/r/f=%b retry=%0d fault=%0d, want %b retry=%0d fault=%0d",
               name, {halt, req, resume, fatal}, retry, fault, eo, er, ef);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eo;
    eo = {m_phase == PH_HALT || m_phase == PH_RB || m_phase == PH_FATAL,
          m_phase == PH_RB, m_phase == PH_RES, m_phase == PH_FATAL};
    check_out(name, eo, m_retry, m_fault);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Accept a mismatch, drain, ack, and step back into IDLE.
  task automatic do_rollback(input string name);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    check_model(name);
    for (int i = 0; i < DRAIN + 4; i++) begin
      if (m_phase == PH_RB) break;
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      check_model(name);
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    check_model(name);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    check_model(name);
  endtask

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
    int         retry;
    int         fault;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic [3:0] i, logic [3:0] o, int r, int f);
    vec_t v;
    v.in    = i;
    v.out   = o;
    v.retry = r;
    v.fault = f;
    return v;
  endfunction

  initial begin
    // in = {cmp_valid, mismatch, ack, clr}; out = {halt, req, resume, fatal}
    tbl[0] = mk(4'b0100, 4'b0000, 0, 0);
    tbl[1] = mk(4'b1100, 4'b1000, 0, 1);
    tbl[2] = mk(4'b1100, 4'b1000, 0, 1);
    tbl[3] = mk(4'b0010, 4'b1000, 0, 1);
    tbl[4] = mk(4'b0001, 4'b1000, 0, 1);
    tbl[5] = mk(4'b0000, 4'b1100, 0, 1);
    tbl[6] = mk(4'b1100, 4'b1100, 0, 1);
    tbl[7] = mk(4'b0000, 4'b1100, 0, 1);
    tbl[8] = mk(4'b0010, 4'b0010, 1, 1);
    tbl[9] = mk(4'b0000, 4'b0000, 1, 1);

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 4'b0000, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      check_model("idle_clean");
    end

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check_out($sformatf("tbl%0d", i), tbl[i].out, tbl[i].retry, tbl[i].fault);
    end

    do_rollback("rb2");
    do_rollback("rb3");
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    check_model("to_fatal");
    check_val("fatal_o", int'(fatal), 1);
    check_val("fatal_retry", int'(retry), 3);
    check_val("fatal_fault", int'(fault), 4);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check_model("fatal_hold");
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    check_model("fatal_clear");
    check_val("clr_retry", int'(retry), 0);
    check_val("clr_fault", int'(fault), 4);
    check_val("clr_halt", int'(halt), 0);

    do_rollback("win_rb");
    for (int i = 0; i < CLEANW - 1; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      check_model("win_wait");
    end
    check_val("win_15", int'(retry), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("win_16", int'(retry), 0);
    do_rollback("post_win1");
    do_rollback("post_win2");
    do_rollback("post_win3");
    check_val("post_win_retry", int'(retry), 3);
    check_val("post_win_fatal", int'(fatal), 0);

    for (int i = 0; i < CLEANW; i++) apply(1'b0, 1'b0, 1'b0, 1'b0);
    check_model("pre_rst");
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DRAIN + 4; i++) begin
      if (m_phase == PH_RB) break;
      apply(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_val("req_before_rst", int'(req), 1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_req", int'(req), 0);
    check_val("rst_async_halt", int'(halt), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    check_model("late_ack");

    for (int i = 0; i < 8000; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      check_model("rand");
    end
    check_val("sat_reached", int'(fault), m_fault);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
